// File: rtl/csi_tx_packet_gen.sv
// csi_tx_packet_gen: CSI-2 transmit packetizer emitting sync, ECC header, payload and CRC-16 footer.
// Ports: clock/reset (sync, active-high), enable (global hold), pkt_req/pkt_type/pkt_wc/pkt_ack
// (packet request handshake), pix_data/pix_valid/pix_ready (payload words, low byte first),
// tx_data/tx_valid/hs_en (lane word stream), underrun/bad_req (single-cycle error pulses).
module csi_tx_packet_gen #(
    parameter logic [1:0]  VC           = 2'd0,
    parameter int          LEAD_CYCLES  = 4,
    parameter int          TRAIL_CYCLES = 4,
    parameter logic [15:0] MAX_WC       = 16'd8192
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        pkt_req,
    input  logic [5:0]  pkt_type,
    input  logic [15:0] pkt_wc,
    output logic        pkt_ack,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    output logic        hs_en,
    output logic        underrun,
    output logic        bad_req
);
    localparam int MAXC = LEAD_CYCLES > TRAIL_CYCLES ? LEAD_CYCLES : TRAIL_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, LEAD, SYNC, HDR0, HDR1, PAYLOAD, CRC, TRAIL} state_t;

    state_t        state, state_n;
    logic [5:0]    typ;
    logic [15:0]   wc, wcnt, crc, req_even, req_wc;
    logic [CW-1:0] cnt;
    logic [7:0]    di, ecc;
    logic          allowed, is_long, req_long;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? (r >> 1) ^ 16'h8408 : r >> 1;
        return r;
    endfunction

    // Each parity bit covers the header bits selected by its mask (d = {WC, DI}).
    function automatic logic [7:0] hdr_ecc(input logic [23:0] d);
        return {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
    endfunction

    assign allowed  = pkt_type <= 6'h03 || (pkt_type >= 6'h10 && pkt_type <= 6'h12) ||
                      (pkt_type >= 6'h28 && pkt_type <= 6'h2D);
    assign req_long = pkt_type > 6'h0F;
    assign req_even = {pkt_wc[15:1], 1'b0};
    assign req_wc   = req_long ? (req_even > MAX_WC ? MAX_WC : req_even) : pkt_wc;
    assign is_long  = typ > 6'h0F;
    assign di       = {VC, typ};
    assign ecc      = hdr_ecc({wc, di});

    always_comb begin
        state_n   = state;
        pkt_ack   = 1'b0;
        bad_req   = 1'b0;
        pix_ready = 1'b0;
        underrun  = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 16'h0000;
        hs_en     = state != IDLE;
        case (state)
            IDLE: begin
                pkt_ack = enable & pkt_req;
                bad_req = pkt_ack & ~allowed;
                if (pkt_ack && allowed) state_n = LEAD_CYCLES > 0 ? LEAD : SYNC;
            end
            LEAD: state_n = cnt == CW'(LEAD_CYCLES - 1) ? SYNC : LEAD;
            SYNC: begin
                tx_valid = 1'b1;
                tx_data  = 16'hB8B8;
                state_n  = HDR0;
            end
            HDR0: begin
                tx_valid = 1'b1;
                tx_data  = {wc[7:0], di};
                state_n  = HDR1;
            end
            HDR1: begin
                tx_valid = 1'b1;
                tx_data  = {ecc, wc[15:8]};
                state_n  = !is_long ? TRAIL : wc == 16'h0000 ? CRC : PAYLOAD;
            end
            PAYLOAD: begin
                tx_valid  = 1'b1;
                pix_ready = enable;
                underrun  = enable & ~pix_valid;
                tx_data   = pix_valid ? pix_data : 16'h0000;
                state_n   = wcnt == 16'd1 ? CRC : PAYLOAD;
            end
            CRC: begin
                tx_valid = 1'b1;
                tx_data  = crc;
                state_n  = TRAIL;
            end
            TRAIL: state_n = cnt == CW'(TRAIL_CYCLES - 1) ? IDLE : TRAIL;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            typ   <= '0;
            wc    <= '0;
            wcnt  <= '0;
            crc   <= 16'hFFFF;
            cnt   <= '0;
        end else if (enable) begin
            state <= state_n;
            cnt   <= (state_n == state && (state == LEAD || state == TRAIL)) ? cnt + 1'b1 : '0;
            if (state == IDLE && pkt_req && allowed) begin
                typ <= pkt_type;
                wc  <= req_wc;
            end
            if (state == HDR1) begin
                crc  <= 16'hFFFF;
                wcnt <= {1'b0, wc[15:1]};
            end
            if (state == PAYLOAD) begin
                crc  <= crc_byte(crc_byte(crc, tx_data[7:0]), tx_data[15:8]);
                wcnt <= wcnt - 16'd1;
            end
        end
    end
endmodule
